// File: rtl/messbauer_pkg.sv
// messbauer_pkg: shared types and default thresholds for the saw-tooth channel detector
package messbauer_pkg;

    localparam int SAMPLE_WIDTH = 12;

    localparam logic [SAMPLE_WIDTH-1:0] WRAP_HIGH_DEF = 12'hF00;
    localparam logic [SAMPLE_WIDTH-1:0] WRAP_LOW_DEF  = 12'h0FF;
    localparam logic [SAMPLE_WIDTH-1:0] MAX_STEP_DEF  = 12'd16;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        RESYNC
    } state_e;

    typedef enum logic [2:0] {
        CLS_HOLD,
        CLS_RISE_OK,
        CLS_RISE_BIG,
        CLS_WRAP,
        CLS_REVERSE
    } slope_class_e;

endpackage

// File: rtl/messbauer_slope_classifier.sv
// messbauer_slope_classifier: combinational classification of a new sample against the previous one
// Ports: prev_i/sample_i (12-bit samples) in, class_o (hold/rise_ok/rise_big/wrap/reverse) out.
module messbauer_slope_classifier
    import messbauer_pkg::*;
#(
    parameter logic [SAMPLE_WIDTH-1:0] WRAP_HIGH = WRAP_HIGH_DEF,
    parameter logic [SAMPLE_WIDTH-1:0] WRAP_LOW  = WRAP_LOW_DEF,
    parameter logic [SAMPLE_WIDTH-1:0] MAX_STEP  = MAX_STEP_DEF
) (
    input  logic [SAMPLE_WIDTH-1:0] prev_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    output slope_class_e            class_o
);

    logic [SAMPLE_WIDTH:0] rise;

    // Extra bit keeps the subtraction from wrapping; only meaningful when sample_i > prev_i.
    assign rise = {1'b0, sample_i} - {1'b0, prev_i};

    always_comb begin
        class_o = sample_i == prev_i ? CLS_HOLD
                : sample_i > prev_i  ? (rise > {1'b0, MAX_STEP} ? CLS_RISE_BIG : CLS_RISE_OK)
                : (prev_i >= WRAP_HIGH && sample_i <= WRAP_LOW) ? CLS_WRAP
                : CLS_REVERSE;
    end

endmodule

// File: rtl/messbauer_saw_tooth_channel_detector.sv
// messbauer_saw_tooth_channel_detector: tracks a 12-bit saw-tooth ramp and emits velocity channel, strobes and error pulses
// Ports: clk, reset (sync, active-high), sample_value/sample_valid in; channel, channel_valid,
// channel_strobe, period_start, reverse_slope, step_error out (all registered, one-cycle latency).
// Optional MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN adds period_length (valid samples per period).
module messbauer_saw_tooth_channel_detector
    import messbauer_pkg::*;
#(
    parameter int                      CHANNEL_BITS = 9,
    parameter logic [SAMPLE_WIDTH-1:0] WRAP_HIGH    = WRAP_HIGH_DEF,
    parameter logic [SAMPLE_WIDTH-1:0] WRAP_LOW     = WRAP_LOW_DEF,
    parameter logic [SAMPLE_WIDTH-1:0] MAX_STEP     = MAX_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_value,
    input  logic                    sample_valid,
    output logic [CHANNEL_BITS-1:0] channel,
    output logic                    channel_valid,
    output logic                    channel_strobe,
    output logic                    period_start,
    output logic                    reverse_slope,
`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
    output logic [23:0]             period_length,
`endif
    output logic                    step_error
);

    localparam int SHIFT = SAMPLE_WIDTH - CHANNEL_BITS;

    state_e                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic [CHANNEL_BITS-1:0] channel_q, channel_d, new_ch;
    logic                    valid_q, valid_d;
    logic                    strobe_q, strobe_d;
    logic                    pstart_q, pstart_d;
    logic                    rev_q, rev_d;
    logic                    step_q, step_d;
    logic                    enter_resync;
    slope_class_e            cls;

    messbauer_slope_classifier #(
        .WRAP_HIGH(WRAP_HIGH),
        .WRAP_LOW (WRAP_LOW),
        .MAX_STEP (MAX_STEP)
    ) u_cls (
        .prev_i  (prev_q),
        .sample_i(sample_value),
        .class_o (cls)
    );

    assign new_ch = CHANNEL_BITS'(sample_value >> SHIFT);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        channel_d    = channel_q;
        valid_d      = valid_q;
        strobe_d     = 1'b0;
        pstart_d     = 1'b0;
        rev_d        = 1'b0;
        step_d       = 1'b0;
        enter_resync = 1'b0;
        if (sample_valid) begin
            prev_d = sample_value;
            case (state_q)
                IDLE: begin
                    channel_d = new_ch;
                    valid_d   = 1'b1;
                    strobe_d  = 1'b1;
                    state_d   = TRACK;
                end
                TRACK: begin
                    case (cls)
                        CLS_RISE_OK: begin
                            channel_d = new_ch;
                            strobe_d  = new_ch != channel_q;
                        end
                        CLS_RISE_BIG: begin
                            step_d       = 1'b1;
                            valid_d      = 1'b0;
                            enter_resync = 1'b1;
                            state_d      = RESYNC;
                        end
                        CLS_WRAP: begin
                            channel_d = new_ch;
                            pstart_d  = 1'b1;
                            strobe_d  = 1'b1;
                        end
                        CLS_REVERSE: begin
                            rev_d        = 1'b1;
                            valid_d      = 1'b0;
                            enter_resync = 1'b1;
                            state_d      = RESYNC;
                        end
                        default: ;
                    endcase
                end
                RESYNC: begin
                    if (cls == CLS_WRAP) begin
                        channel_d = new_ch;
                        valid_d   = 1'b1;
                        pstart_d  = 1'b1;
                        strobe_d  = 1'b1;
                        state_d   = TRACK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            channel_q <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            pstart_q  <= 1'b0;
            rev_q     <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            channel_q <= channel_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            pstart_q  <= pstart_d;
            rev_q     <= rev_d;
            step_q    <= step_d;
        end
    end

`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
    logic [23:0] cnt_q, cnt_d, len_q, len_d;

    // The wrapping sample is the first sample of the new period, so the count restarts at 1.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (sample_valid) begin
            cnt_d = (state_q == IDLE || pstart_d) ? 24'd1
                  : enter_resync                  ? 24'd0
                  : &cnt_q                        ? cnt_q
                  : cnt_q + 24'd1;
            len_d = pstart_d ? cnt_q : enter_resync ? 24'd0 : len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign period_length = len_q;
`endif

    assign channel        = channel_q;
    assign channel_valid  = valid_q;
    assign channel_strobe = strobe_q;
    assign period_start   = pstart_q;
    assign reverse_slope  = rev_q;
    assign step_error     = step_q;

endmodule

// File: tb/tb_messbauer_saw_tooth_channel_detector.sv
// tb_messbauer_saw_tooth_channel_detector: scripted and randomized checks against a rule-level reference model
module tb_messbauer_saw_tooth_channel_detector;

    localparam int CB = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [11:0]   sample_value = '0;
    logic          sample_valid = 1'b0;
    logic [CB-1:0] channel;
    logic          channel_valid, channel_strobe, period_start, reverse_slope, step_error;
`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
    logic [23:0]   period_length;
`endif

    int errs = 0;
    int checks = 0;

    // reference model: plain rule-level bookkeeping
    bit m_have, m_locked, m_valid, m_strobe, m_ps, m_rev, m_step;
    int m_prev, m_ch, m_cnt, m_len;
    int strobe_count;

    always #5 clk = ~clk;

    messbauer_saw_tooth_channel_detector #(.CHANNEL_BITS(CB)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_value  (sample_value),
        .sample_valid  (sample_valid),
        .channel       (channel),
        .channel_valid (channel_valid),
        .channel_strobe(channel_strobe),
        .period_start  (period_start),
        .reverse_slope (reverse_slope),
`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
        .period_length (period_length),
`endif
        .step_error    (step_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_valid = 0; m_strobe = 0; m_ps = 0; m_rev = 0; m_step = 0;
        m_prev = 0; m_ch = 0; m_cnt = 0; m_len = 0;
    endtask

    task automatic model_sample(input int v);
        int  ch;
        bit  wrap, lost;
        ch = v / (1 << (12 - CB));
        wrap = v < m_prev && m_prev >= 'hF00 && v <= 'h0FF;
        lost = 0;
        m_strobe = 0; m_ps = 0; m_rev = 0; m_step = 0;
        if (!m_have) begin
            m_have = 1; m_locked = 1; m_valid = 1; m_strobe = 1; m_ch = ch; m_cnt = 1;
        end else begin
            if (m_locked) begin
                if (v > m_prev && v - m_prev <= 16) begin
                    m_strobe = ch != m_ch;
                    m_ch = ch;
                end else if (v > m_prev) begin
                    m_step = 1; lost = 1;
                end else if (wrap) begin
                    m_ps = 1; m_strobe = 1; m_ch = ch;
                end else if (v < m_prev) begin
                    m_rev = 1; lost = 1;
                end
            end else if (wrap) begin
                m_ps = 1; m_strobe = 1; m_valid = 1; m_locked = 1; m_ch = ch;
            end
            if (lost) begin
                m_locked = 0; m_valid = 0; m_cnt = 0; m_len = 0;
            end else if (m_ps) begin
                m_len = m_cnt; m_cnt = 1;
            end else if (m_cnt < 'hFFFFFF) begin
                m_cnt++;
            end
        end
        m_prev = v;
    endtask

    task automatic compare_all();
        chk("channel", 32'(channel), 32'(m_ch));
        chk("channel_valid", 32'(channel_valid), 32'(m_valid));
        chk("channel_strobe", 32'(channel_strobe), 32'(m_strobe));
        chk("period_start", 32'(period_start), 32'(m_ps));
        chk("reverse_slope", 32'(reverse_slope), 32'(m_rev));
        chk("step_error", 32'(step_error), 32'(m_step));
`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
        chk("period_length", 32'(period_length), 32'(m_len));
`endif
    endtask

    task automatic drive(input bit vld, input int v);
        sample_valid = vld;
        sample_value = 12'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        if (vld) model_sample(v);
        else begin
            m_strobe = 0; m_ps = 0; m_rev = 0; m_step = 0;
        end
        if (channel_strobe) strobe_count++;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    task automatic ramp(input int from, input int to, input int st, input bit gaps);
        for (int v = from; v <= to; v += st) begin
            drive(1'b1, v);
            if (gaps) drive(1'b0, v);
        end
    endtask

    initial begin
        int v, r;
        model_reset();
        do_reset();
        chk("reset_channel_valid", 32'(channel_valid), 32'd0);

        // full-rate ramp: 512 channels, 511 strobes after the first sample
        drive(1'b1, 0);
        strobe_count = 0;
        ramp(8, 4088, 8, 1'b0);
        chk("ramp_strobes", 32'(strobe_count), 32'd511);
        chk("ramp_top_channel", 32'(channel), 32'd511);

        // wrap
        drive(1'b1, 0);
        chk("wrap_period_start", 32'(period_start), 32'd1);
        chk("wrap_channel", 32'(channel), 32'd0);
        chk("wrap_strobe", 32'(channel_strobe), 32'd1);
`ifdef MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN
        chk("wrap_period_length", 32'(period_length), 32'd512);
`endif

        // reverse slope, then recovery on the next wrap
        ramp(8, 2000, 8, 1'b0);
        drive(1'b1, 1990);
        chk("reverse_pulse", 32'(reverse_slope), 32'd1);
        chk("reverse_valid", 32'(channel_valid), 32'd0);
        ramp(1998, 4088, 10, 1'b0);
        drive(1'b1, 4088);
        drive(1'b1, 0);
        chk("recover_period_start", 32'(period_start), 32'd1);
        chk("recover_valid", 32'(channel_valid), 32'd1);

        // step error, no strobes until next wrap
        ramp(4, 100, 4, 1'b0);
        drive(1'b1, 140);
        chk("step_pulse", 32'(step_error), 32'd1);
        strobe_count = 0;
        ramp(148, 4088, 8, 1'b0);
        chk("resync_no_strobe", 32'(strobe_count), 32'd0);
        drive(1'b1, 0);
        chk("step_recover_ps", 32'(period_start), 32'd1);

        // reset mid-ramp
        ramp(16, 800, 16, 1'b0);
        do_reset();
        chk("midreset_channel", 32'(channel), 32'd0);
        chk("midreset_valid", 32'(channel_valid), 32'd0);
        drive(1'b1, 300);
        chk("after_reset_channel", 32'(channel), 32'd37);
        chk("after_reset_valid", 32'(channel_valid), 32'd1);
        chk("after_reset_no_ps", 32'(period_start), 32'd0);

        // half-rate ramp
        do_reset();
        strobe_count = 0;
        ramp(0, 4088, 8, 1'b1);
        chk("halfrate_strobes", 32'(strobe_count), 32'd512);
        chk("halfrate_top_channel", 32'(channel), 32'd511);

        // randomized walk
        v = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                do_reset();
                continue;
            end
            r = int'($urandom_range(0, 99));
            if (r < 70) v = v + int'($urandom_range(0, 16));
            else if (r < 76) v = v + int'($urandom_range(17, 60));
            else if (r < 82) v = v - int'($urandom_range(1, 20));
            else if (r < 95) v = (v >= 'hF00) ? int'($urandom_range(0, 'h0FF)) : v + int'($urandom_range(0, 16));
            else v = int'($urandom_range(0, 4095));
            if (v > 4095) v = int'($urandom_range(0, 300));
            if (v < 0) v = 0;
            drive($urandom_range(0, 9) < 8, v);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/messbauer_saw_tooth_channel_detector.md
# messbauer_saw_tooth_channel_detector

Receiver-side companion of the Messbauer saw-tooth velocity generator. It consumes the generator's 12-bit ramp samples and produces four things: a velocity channel number, a channel-change strobe, a period-start pulse, and reverse-slope and step errors. It sits between the velocity reference path and the spectrum accumulator, and gives the accumulator the channel address for each detector count.

## Interface
- CHANNEL_BITS, default 9: channel index width, 1..12; channel = sample >> (12 − CHANNEL_BITS).
- WRAP_HIGH, default 12'hF00: previous sample must be ≥ this for a drop to count as wrap-around.
- WRAP_LOW, default 12'h0FF: new sample must be ≤ this for a drop to count as wrap-around.
- MAX_STEP, default 12'd16: largest legal rising step between consecutive valid samples.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_value  in  12  saw-tooth sample from the generator.
- sample_valid  in  1  sample_value is a new sample this cycle.
- channel  out  CHANNEL_BITS  current velocity channel.
- channel_valid  out  1  channel holds a tracked value.
- channel_strobe  out  1  one-cycle pulse when channel changes or a period starts.
- period_start  out  1  one-cycle pulse on a detected wrap.
- reverse_slope  out  1  one-cycle pulse on an illegal decrease.
- step_error  out  1  one-cycle pulse when a rise exceeds MAX_STEP.

## Operation
- States:
  - IDLE: no reference sample held.
  - TRACK: reference sample held, ramp in progress.
  - RESYNC: recovering after an error.
- Reset: state=IDLE; prev=0; channel=0; every output is 0.
- IDLE, on sample_valid:
  - store prev = sample; load channel; channel_valid=1; channel_strobe=1.
  - go to TRACK. No period_start is issued for the first sample.
- TRACK, on sample_valid, sample s compared with prev p (unsigned 12-bit; differences computed in 13 bits, no wrap in the subtraction):
  - s == p: hold; no pulses.
  - s > p and s − p ≤ MAX_STEP: update channel; channel_strobe if the channel changed.
  - s > p and s − p > MAX_STEP: step_error; go to RESYNC.
  - s < p, p ≥ WRAP_HIGH and s ≤ WRAP_LOW: period_start and channel_strobe; channel reloaded.
  - s < p otherwise: reverse_slope; channel_valid=0; go to RESYNC.
  - In every case prev = s.
- RESYNC: channel_valid stays 0 and no channel_strobe is issued. On the first wrap detected by the TRACK rules, assert period_start, set channel_valid=1, pulse channel_strobe and go to TRACK. All other samples only update prev.
- Cycles with sample_valid=0 change no state and produce no pulses.
- reset asserted mid-operation overrides everything on that edge: return to IDLE, all outputs 0 on the next cycle.
- period_start and reverse_slope are mutually exclusive. step_error and reverse_slope are mutually exclusive.

## Timing
- Latency is one cycle: outputs are registered, and all pulses and the new channel appear on the cycle after the edge that sampled sample_valid=1.
- Back-to-back samples (sample_valid high every cycle) are supported at full rate.
- No backpressure; samples are never dropped.
- Pulses are exactly one cycle wide.

## Configuration
- MESSBAUER_SAW_TOOTH_PERIOD_MEASURE_EN defined:
  - adds output period_length (24 bits). It is a count of valid samples between consecutive period_start pulses.
  - The count is latched on period_start and saturates at 24'hFFFFFF.
  - It clears to 0 on reset and on entry to RESYNC.
- Macro undefined: no period_length port and no counter logic.

## Structure
- Package messbauer_pkg holds:
  - the state enum (IDLE, TRACK, RESYNC);
  - SAMPLE_WIDTH=12;
  - the default WRAP_HIGH, WRAP_LOW and MAX_STEP constants.
- One sub-module: messbauer_slope_classifier. It is combinational; it takes p and s and returns the class: hold, rise_ok, rise_big, wrap or reverse.
- The top module holds the FSM, the channel register and the optional period counter.

## Test plan
- Reset with CHANNEL_BITS=9, then samples 0,8,16,…,4088 one per cycle:
  - channel advances 0→511 with exactly 511 channel_strobe pulses after the first;
  - no errors.
- Ramp to 4088, then sample 0:
  - period_start pulses once, channel=0, channel_strobe=1 in the same cycle.
  - With the macro defined, period_length=512.
- Ramp to 2000, then sample 1990:
  - reverse_slope pulse, channel_valid=0.
  - A subsequent ramp to 4088 followed by 0 restores channel_valid=1 with period_start.
- Samples 100 then 140:
  - step_error pulse; no channel_strobe until the next wrap.
- Assert reset for one cycle in the middle of a ramp:
  - all outputs 0 the next cycle;
  - the next sample (e.g. 300) gives channel=37, channel_valid=1, no period_start.
- Alternate sample_valid 1/0 over the ramp:
  - identical channel sequence to the full-rate case;
  - no pulses on idle cycles.
